// File: rtl/ec_point_unit.sv
// Affine point add/double for y^2 = x^3 + a*x + b over GF(PRIME).
// One bit-serial modular multiplier is shared by every product, including Fermat inversion.
module ec_point_unit #(
   parameter int               WIDTH   = 256,
   parameter logic [WIDTH-1:0] PRIME   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
   parameter logic [WIDTH-1:0] CURVE_A = '0
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             op_double,
   input  logic [WIDTH-1:0] p_x,
   input  logic [WIDTH-1:0] p_y,
   input  logic             p_inf,
   input  logic [WIDTH-1:0] q_x,
   input  logic [WIDTH-1:0] q_y,
   input  logic             q_inf,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r_x,
   output logic [WIDTH-1:0] r_y,
   output logic             r_inf
);

   function automatic int top_bit(input logic [WIDTH-1:0] e);
      int r;
      r = 0;
      for (int i = 0; i < WIDTH; i++) if (e[i]) r = i;
      return r;
   endfunction

   localparam logic [WIDTH-1:0] E   = PRIME - WIDTH'(2);
   localparam int               HB  = top_bit(E);
   localparam int               BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int               MCW = $clog2(WIDTH + 2);
   localparam logic [WIDTH:0]   PW1 = {1'b0, PRIME};
   localparam logic [WIDTH+1:0] PW2 = {2'b0, PRIME};

   function automatic logic [WIDTH-1:0] fadd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= PW1) s = s - PW1;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] fsub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} - {1'b0, b};
      if (s[WIDTH]) s = s + PW1;
      return s[WIDTH-1:0];
   endfunction

   typedef enum logic [3:0] {
      IDLE, CHECK, SQX, PREP, INV, LAM, LSQ, XSUB, USUB, YMUL, YSUB
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] x1, y1, x2, y2;
   logic             i1, i2, dbl, sp_inf;
   logic [WIDTH-1:0] t, num, den, inv, lam, u, v, x3;
   logic [BW-1:0]    ibit;
   logic             imul;
   logic [MCW-1:0]   mcnt;
   logic [WIDTH-1:0] ma, mb, macc;

   logic [WIDTH-1:0] op_a, op_b, prep_num, prep_den, mnext;
   logic [WIDTH+1:0] m0, m1, m2;

   // acc = 2*acc + a_msb*b stays below 3p, so two trial subtractions suffice
   always_comb begin
      m0    = {1'b0, macc, 1'b0} + (ma[WIDTH-1] ? {2'b0, mb} : '0);
      m1    = (m0 >= PW2) ? m0 - PW2 : m0;
      m2    = (m1 >= PW2) ? m1 - PW2 : m1;
      mnext = m2[WIDTH-1:0];
   end

   always_comb begin
      op_a = inv;
      op_b = inv;
      case (state)
         SQX:     begin op_a = x1;  op_b = x1;  end
         INV:     begin op_a = inv; op_b = imul ? den : inv; end
         LAM:     begin op_a = num; op_b = inv; end
         LSQ:     begin op_a = lam; op_b = lam; end
         YMUL:    begin op_a = lam; op_b = u;   end
         default: ;
      endcase
   end

   always_comb begin
      if (dbl) begin
         prep_num = fadd(fadd(fadd(t, t), t), CURVE_A);
         prep_den = fadd(y1, y1);
      end else begin
         prep_num = fsub(y2, y1);
         prep_den = fsub(x2, x1);
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         r_x   <= '0;
         r_y   <= '0;
         r_inf <= 1'b1;
         mcnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               x1 <= p_x;  y1 <= p_y;  i1 <= p_inf;
               x2 <= q_x;  y2 <= q_y;  i2 <= q_inf;
               dbl   <= op_double;
               busy  <= 1'b1;
               state <= CHECK;
            end
            CHECK: begin
               // Special results are parked as (x3, v - y1) with y1 = 0 so YSUB emits them unchanged
               state  <= YSUB;
               sp_inf <= 1'b1;
               x3     <= '0;
               v      <= '0;
               y1     <= '0;
               if (!dbl && i1) begin
                  sp_inf <= i2;
                  x3     <= i2 ? '0 : x2;
                  v      <= i2 ? '0 : y2;
               end else if (!dbl && i2) begin
                  sp_inf <= 1'b0;
                  x3     <= x1;
                  v      <= y1;
               end else if (!dbl && x1 == x2 && y1 != y2) begin
                  sp_inf <= 1'b1;
               end else if ((dbl && i1) || ((dbl || x1 == x2) && y1 == '0)) begin
                  sp_inf <= 1'b1;
               end else begin
                  sp_inf <= 1'b0;
                  y1     <= y1;
                  if (dbl || x1 == x2) begin
                     x2    <= x1;
                     y2    <= y1;
                     dbl   <= 1'b1;
                     state <= SQX;
                  end else begin
                     state <= PREP;
                  end
               end
            end
            PREP: begin
               num   <= prep_num;
               den   <= prep_den;
               inv   <= prep_den;
               ibit  <= BW'(HB - 1);
               imul  <= 1'b0;
               state <= (HB == 0) ? LAM : INV;
            end
            SQX, INV, LAM, LSQ, YMUL: begin
               if (mcnt == '0) begin
                  ma   <= op_a;
                  mb   <= op_b;
                  macc <= '0;
                  mcnt <= mcnt + 1'b1;
               end else if (mcnt <= MCW'(WIDTH)) begin
                  macc <= mnext;
                  ma   <= ma << 1;
                  mcnt <= mcnt + 1'b1;
               end else begin
                  mcnt <= '0;
                  case (state)
                     SQX: begin t <= macc; state <= PREP; end
                     INV: begin
                        inv <= macc;
                        if (!imul && E[ibit]) imul <= 1'b1;
                        else if (ibit == '0) state <= LAM;
                        else begin
                           ibit <= ibit - 1'b1;
                           imul <= 1'b0;
                        end
                     end
                     LAM:     begin lam <= macc; state <= LSQ; end
                     LSQ:     begin t   <= macc; state <= XSUB; end
                     default: begin v   <= macc; state <= YSUB; end
                  endcase
               end
            end
            XSUB: begin x3 <= fsub(fsub(t, x1), x2); state <= USUB; end
            USUB: begin u  <= fsub(x1, x3);          state <= YMUL; end
            YSUB: begin
               r_x   <= x3;
               r_y   <= fsub(v, y1);
               r_inf <= sp_inf;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ec_point_unit.sv
// Bench for ec_point_unit on y^2 = x^3 + 2x + 2 over GF(17): directed table, protocol sequences, random ops vs. model.
module tb_ec_point_unit;
   localparam int W = 5;
   localparam int P = 17;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         Reset = 1'b1;
   logic         start = 1'b0, op_double = 1'b0, p_inf = 1'b0, q_inf = 1'b0;
   logic [W-1:0] p_x = '0, p_y = '0, q_x = '0, q_y = '0;
   logic         busy, done, r_inf;
   logic [W-1:0] r_x, r_y;

   ec_point_unit #(.WIDTH(W), .PRIME(5'd17), .CURVE_A(5'd2)) dut (
      .clk(clk), .Reset(Reset), .start(start), .op_double(op_double),
      .p_x(p_x), .p_y(p_y), .p_inf(p_inf), .q_x(q_x), .q_y(q_y), .q_inf(q_inf),
      .busy(busy), .done(done), .r_x(r_x), .r_y(r_y), .r_inf(r_inf)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit dbl; int px; int py; bit pi; int qx; int qy; bit qi;
      int rx; int ry; bit ri; int lat;
   } vec_t;

   int passed = 0, total = 0;
   int l_add, l_dbl;
   int ptx[$], pty[$];
   vec_t tbl[9];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int md(input int a);
      return ((a % P) + P) % P;
   endfunction

   function automatic int minv(input int d);
      for (int k = 1; k < P; k++) if (md(d * k) == 1) return k;
      return 0;
   endfunction

   // Textbook affine group law with the degenerate cases resolved first
   function automatic vec_t model(input bit dbl, input int px, input int py, input bit pi,
                                  input int qx, input int qy, input bit qi);
      vec_t r;
      int lam, x3;
      r.dbl = dbl; r.px = px; r.py = py; r.pi = pi; r.qx = qx; r.qy = qy; r.qi = qi;
      r.rx = 0; r.ry = 0; r.ri = 1; r.lat = 2;
      if (!dbl && pi) begin
         r.ri = qi; r.rx = qi ? 0 : qx; r.ry = qi ? 0 : qy;
         return r;
      end
      if (!dbl && qi) begin
         r.ri = 0; r.rx = px; r.ry = py;
         return r;
      end
      if (!dbl && px == qx && py != qy) return r;
      if (dbl || px == qx) begin
         if (pi || py == 0) return r;
         lam = md((3 * px * px + A) * minv(md(2 * py)));
         qx = px;
         r.lat = l_dbl;
      end else begin
         lam = md(md(qy - py) * minv(md(qx - px)));
         r.lat = l_add;
      end
      x3 = md(lam * lam - px - qx);
      r.ri = 0; r.rx = x3; r.ry = md(lam * (px - x3) - py);
      return r;
   endfunction

   task automatic drive(input vec_t v);
      op_double = v.dbl;
      p_x = W'(v.px); p_y = W'(v.py); p_inf = v.pi;
      q_x = W'(v.qx); q_y = W'(v.qy); q_inf = v.qi;
   endtask

   task automatic run_op(input vec_t v, input int inj, input int rst_at, input string nm);
      int got, dn;
      got = -1;
      @(negedge clk);
      drive(v);
      start = 1'b1;
      @(posedge clk); #1;
      chk({nm, " busy_after_accept"}, int'(busy), 1);
      chk({nm, " done_low_after_accept"}, int'(done), 0);
      for (int k = 1; k <= 200 && got < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == inj) begin
            start = 1'b1; op_double = 1'b1; p_x = 5'd6; p_y = 5'd3; p_inf = 1'b0;
         end
         if (k == rst_at) Reset = 1'b1;
         @(posedge clk); #1;
         if (k == rst_at) begin
            chk({nm, " rst_busy"}, int'(busy), 0);
            chk({nm, " rst_done"}, int'(done), 0);
            chk({nm, " rst_rx"}, int'(r_x), 0);
            chk({nm, " rst_ry"}, int'(r_y), 0);
            chk({nm, " rst_rinf"}, int'(r_inf), 1);
            @(negedge clk);
            Reset = 1'b0;
            dn = 0;
            repeat (80) begin
               @(posedge clk); #1;
               if (done) dn++;
            end
            chk({nm, " no_done_after_abort"}, dn, 0);
            return;
         end
         if (done) got = k;
      end
      chk({nm, " latency"}, got, v.lat);
      if (got >= 0) begin
         chk({nm, " r_inf"}, int'(r_inf), int'(v.ri));
         chk({nm, " r_x"}, int'(r_x), v.rx);
         chk({nm, " r_y"}, int'(r_y), v.ry);
         chk({nm, " busy_low_at_done"}, int'(busy), 0);
      end
   endtask

   initial begin
      int e, hb, pc, ni;
      vec_t rv;
      e = P - 2; hb = 0; pc = 0;
      for (int i = 0; i < 31; i++) if ((e >> i) & 1) begin hb = i; pc++; end
      ni = hb + pc - 1;
      l_add = 5 + (ni + 3) * (W + 2);
      l_dbl = 5 + (ni + 4) * (W + 2);
      for (int x = 0; x < P; x++)
         for (int y = 0; y < P; y++)
            if (md(y * y) == md(x * x * x + A * x + 2)) begin ptx.push_back(x); pty.push_back(y); end

      //          dbl px py pi qx  qy qi  rx  ry ri lat
      tbl[0] = '{1, 5, 1, 0, 0,  0, 0,  6,  3, 0, 75};
      tbl[1] = '{0, 5, 1, 0, 6,  3, 0, 10,  6, 0, 68};
      tbl[2] = '{0, 5, 1, 0, 5,  1, 0,  6,  3, 0, 75};
      tbl[3] = '{0, 5, 1, 0, 5, 16, 0,  0,  0, 1,  2};
      tbl[4] = '{0, 0, 0, 1, 6,  3, 0,  6,  3, 0,  2};
      tbl[5] = '{0, 10, 6, 0, 0, 0, 1, 10,  6, 0,  2};
      tbl[6] = '{1, 0, 0, 1, 0,  0, 0,  0,  0, 1,  2};
      tbl[7] = '{1, 3, 0, 0, 0,  0, 0,  0,  0, 1,  2};
      tbl[8] = '{0, 0, 0, 1, 0,  0, 1,  0,  0, 1,  2};

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset r_x", int'(r_x), 0);
      chk("reset r_y", int'(r_y), 0);
      chk("reset r_inf", int'(r_inf), 1);
      @(negedge clk);
      Reset = 1'b0;

      // Consecutive calls land start in the done cycle, so these are back-to-back
      for (int i = 0; i < 9; i++) run_op(tbl[i], 0, 0, $sformatf("tbl%0d", i));

      run_op(tbl[1], 10, 0, "restart_ignored");
      run_op(tbl[1], 0, 30, "reset_abort");
      run_op(tbl[1], 0, 0, "after_reset");
      run_op(tbl[0], 0, 0, "after_reset_b2b");

      for (int n = 0; n < 40; n++) begin
         int i, j, mode, qx, qy;
         i = $urandom_range(0, ptx.size() - 1);
         j = $urandom_range(0, ptx.size() - 1);
         mode = $urandom_range(0, 5);
         qx = ptx[j]; qy = pty[j];
         if (mode == 0) begin qx = ptx[i]; qy = pty[i]; end
         if (mode == 1) begin qx = ptx[i]; qy = md(P - pty[i]); end
         rv = model($urandom_range(0, 3) == 0, ptx[i], pty[i], $urandom_range(0, 7) == 0,
                    qx, qy, $urandom_range(0, 7) == 0);
         run_op(rv, 0, 0, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
